mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle integer multiply/divide unit downstream of the register bank.
//  Consumes the two read-port operands (data1/data2) and produces a 64-bit
//  result in internal HI/LO registers, read by the writeback path.
//  Iterative shift-add multiply and restoring divide: one bit per cycle, single datapath.
// PARAMETERS
//  WIDTH    32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      request; sampled only in IDLE
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  operandA   in   WIDTH  multiplicand / dividend (register bank data1)
//  operandB   in   WIDTH  multiplier / divisor (register bank data2)
//  writeHi    in   1      MTHI: HI <= writeData (IDLE only)
//  writeLo    in   1      MTLO: LO <= writeData (IDLE only)
//  writeData  in   WIDTH  data for writeHi/writeLo
//  busy       out  1      high while an operation is in flight
//  done       out  1      one-cycle pulse; HI/LO valid from this cycle
//  divByZero  out  1      high with done when DIV/DIVU had operandB==0
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0; done=0; divByZero=0; hi=0; lo=0; counter=0.
//  - FSM: IDLE -> MUL|DIV (start=1) -> FIX -> IDLE.
//    IDLE: on start, latch op, operand magnitudes (signed ops) or raw values
//      (unsigned ops), and the result signs; counter=WIDTH; busy=1 next cycle.
//    MUL: one shift-add per cycle; counter decrements; after WIDTH cycles -> FIX.
//    DIV: one restoring-subtract step per cycle; after WIDTH cycles -> FIX.
//    FIX: apply sign correction; on exit edge write hi/lo, pulse done=1,
//      set busy=0.
//  - Latency: start sampled at edge E0; done=1 in the cycle after E0+WIDTH+1
//    (34 cycles for WIDTH=32). hi/lo hold old values until that edge.
//  - Sign rules: MULT negates the 2*WIDTH product if the operand signs differ.
//    DIV negates the quotient if the signs differ; the remainder takes the
//    dividend's sign. LO=quotient or product[WIDTH-1:0];
//    HI=remainder or product[2*WIDTH-1:WIDTH].
//  - Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps,
//    no flag).
//  - Divide by zero: IDLE goes straight to FIX with no iterations.
//    Result: HI=operandA, LO=all-ones, divByZero=1 with done.
//    Latency 2 cycles.
//  - divByZero: registered; cleared on the next accepted start.
//  - start while busy: ignored, no queueing. A start in the done cycle is
//    accepted (state is IDLE).
//  - writeHi/writeLo while busy: ignored.
//    If writeHi/writeLo and start occur together in IDLE, the write lands
//    and start is also accepted. The result overwrites the write at completion.
//  - Reset mid-operation: aborts immediately; all outputs return to reset values.
//  - done is never asserted without a preceding accepted start.
// STRUCTURE
//  - Shared package mdu_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV,
//    OP_DIVU), FSM state encoding, ITER_CNT_W = $clog2(WIDTH+1).
//  - One sub-module mdu_shift_core: combinational single-step datapath.
//    MUL step: conditional add, then shift the {acc,mplier} right.
//    DIV step: shift {rem,quot} left, trial subtract, set the quotient bit.
//    The top level owns the FSM, counter, sign fix and the HI/LO registers.
// TESTING
//  - MULTU 12*6 -> LO=72, HI=0, done exactly 34 cycles after start, busy low after.
//  - MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//    MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU 100/7 -> LO=14, HI=2.
//    DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  - DIVU 100/0 -> done 2 cycles after start, divByZero=1, HI=100, LO=0xFFFFFFFF.
//    The next start clears divByZero.
//  - start pulsed at cycle 10 of a MULT: ignored, original result delivered.
//    Back-to-back start in the done cycle is accepted.
//    writeLo=0x55 while busy has no effect.
//  - reset asserted mid-DIV (cycle 15): busy/done/hi/lo clear asynchronously.
//    After release, MTHI 0xAB gives hi=0xAB next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings as presented on the op port
//   - FSM state encoding
//   - iteration counter width for the default 32-bit datapath
package mdu_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int ITER_CNT_W = $clog2(MDU_WIDTH + 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_shift_core.sv
// Combinational single-step datapath shared by multiply and divide.
// Ports:
//   is_div   in   1      0: shift-add multiply step, 1: restoring divide step
//   work_hi  in   WIDTH  accumulator (multiply) / partial remainder (divide)
//   work_lo  in   WIDTH  multiplier bits (multiply) / dividend-quotient (divide)
//   opnd     in   WIDTH  multiplicand (multiply) / divisor (divide)
//   next_hi  out  WIDTH  work_hi after one step
//   next_lo  out  WIDTH  work_lo after one step
module mdu_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] work_hi,
    input  logic [WIDTH-1:0] work_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    always_comb begin
        // Multiply: add the multiplicand when the low multiplier bit is set,
        // then shift {carry, acc, mplier} right by one.
        addend  = work_lo[0] ? opnd : '0;
        mul_sum = {1'b0, work_hi} + {1'b0, addend};

        // Divide: shift {rem, quot} left by one, then trial-subtract.
        // The partial remainder is always below the divisor, so the
        // difference (when taken) fits in WIDTH bits and modular subtract
        // gives the exact value.
        shifted = {work_hi, work_lo[WIDTH-1]};
        div_ge  = (shifted >= {1'b0, opnd});
        div_sub = shifted[WIDTH-1:0] - opnd;

        if (is_div) begin
            next_hi = div_ge ? div_sub : shifted[WIDTH-1:0];
            next_lo = {work_lo[WIDTH-2:0], div_ge};
        end else begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit (one bit per cycle).
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset, clears all state
//   start      in   1      request, sampled only in IDLE
//   op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operandA   in   WIDTH  multiplicand / dividend
//   operandB   in   WIDTH  multiplier / divisor
//   writeHi    in   1      MTHI (IDLE only)
//   writeLo    in   1      MTLO (IDLE only)
//   writeData  in   WIDTH  data for writeHi/writeLo
//   busy       out  1      operation in flight
//   done       out  1      one-cycle pulse, hi/lo valid from this cycle
//   divByZero  out  1      set with done when a divide had operandB==0
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH == MDU_WIDTH) ? ITER_CNT_W : $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return n ? -sv : sv;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
        logic signed [2*WIDTH-1:0] sv;
        sv = v;
        return n ? -sv : sv;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             dz_pend_q, dz_pend_d;
    logic             is_div_q, is_div_d;
    logic             neg_p_q, neg_p_d;   // negate product / quotient
    logic             neg_r_q, neg_r_d;   // negate remainder
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e                     op_sel;
    logic                    is_div_op, signed_op, a_neg, b_neg, div_zero;
    logic signed [WIDTH-1:0] op_a_s, op_b_s;
    logic [WIDTH-1:0]        a_mag, b_mag;
    logic [WIDTH-1:0]        step_hi, step_lo;
    logic [2*WIDTH-1:0]      prod_fix;

    // Operand preparation for the request presented in IDLE.
    always_comb begin
        op_sel    = op_e'(op);
        op_a_s    = operandA;
        op_b_s    = operandB;
        is_div_op = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
        signed_op = (op_sel == OP_MULT) || (op_sel == OP_DIV);
        a_neg     = signed_op && (op_a_s < 0);
        b_neg     = signed_op && (op_b_s < 0);
        a_mag     = cond_neg(operandA, a_neg);
        b_mag     = cond_neg(operandB, b_neg);
        div_zero  = is_div_op && (operandB == '0);
    end

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (is_div_q),
        .work_hi (work_hi_q),
        .work_lo (work_lo_q),
        .opnd    (opnd_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        dz_pend_d = dz_pend_q;
        is_div_d  = is_div_q;
        neg_p_d   = neg_p_q;
        neg_r_d   = neg_r_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_fix  = cond_neg2({work_hi_q, work_lo_q}, neg_p_q);

        unique case (state_q)
            ST_IDLE: begin
                if (writeHi) hi_d = writeData;
                if (writeLo) lo_d = writeData;
                if (start) begin
                    busy_d    = 1'b1;
                    dz_d      = 1'b0;
                    dz_pend_d = div_zero;
                    is_div_d  = is_div_op;
                    cnt_d     = CNT_W'(WIDTH);
                    if (div_zero) begin
                        // No iterations: FIX publishes HI=dividend, LO=all-ones.
                        work_hi_d = operandA;
                        work_lo_d = '1;
                        opnd_d    = '0;
                        neg_p_d   = 1'b0;
                        neg_r_d   = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_FIX;
                    end else if (is_div_op) begin
                        work_hi_d = '0;
                        work_lo_d = a_mag;
                        opnd_d    = b_mag;
                        neg_p_d   = a_neg ^ b_neg;
                        neg_r_d   = a_neg;
                        state_d   = ST_DIV;
                    end else begin
                        work_hi_d = '0;
                        work_lo_d = b_mag;
                        opnd_d    = a_mag;
                        neg_p_d   = a_neg ^ b_neg;
                        neg_r_d   = 1'b0;
                        state_d   = ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = cond_neg(work_hi_q, neg_r_q);
                    lo_d = cond_neg(work_lo_q, neg_p_q);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d    = 1'b1;
                busy_d    = 1'b0;
                dz_d      = dz_pend_q;
                dz_pend_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            is_div_q  <= 1'b0;
            neg_p_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
            is_div_q  <= is_div_d;
            neg_p_q   <= neg_p_d;
            neg_r_q   <= neg_r_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign divByZero = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         writeHi;
    logic         writeLo;
    logic [W-1:0] writeData;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .writeHi   (writeHi),
        .writeLo   (writeLo),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // inject: 0 none, 1 start+writeLo pulsed mid-operation, 2 writeHi together with start
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int exp_lat, input logic exp_dz, input int inject);
        int n;
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        if (inject == 2) begin
            writeHi   = 1'b1;
            writeData = 32'h0000_1234;
        end
        tick;
        start   = 1'b0;
        writeHi = 1'b0;
        if (inject == 2) cur_hi = 32'h0000_1234;
        chk({tag, "/busy_start"}, 64'(busy), 64'd1);
        chk({tag, "/dz_cleared"}, 64'(divByZero), 64'd0);
        chk({tag, "/hilo_hold"}, {hi, lo}, {cur_hi, cur_lo});
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 9 && inject == 1) begin
                start     = 1'b1;
                op        = OP_DIVU;
                operandA  = 32'd1;
                operandB  = 32'd0;
                writeLo   = 1'b1;
                writeData = 32'h0000_0055;
            end
            tick;
            n++;
            start   = 1'b0;
            writeLo = 1'b0;
            if (n == 10 && inject == 1) begin
                chk({tag, "/busy_write_ignored"}, {hi, lo}, {cur_hi, cur_lo});
                chk({tag, "/busy_still"}, 64'(busy), 64'd1);
            end
        end
        chk({tag, "/latency"}, 64'(n + 1), 64'(exp_lat));
        chk({tag, "/done"}, 64'(done), 64'd1);
        chk({tag, "/busy_end"}, 64'(busy), 64'd0);
        chk({tag, "/hi"}, 64'(hi), 64'(eh));
        chk({tag, "/lo"}, 64'(lo), 64'(el));
        chk({tag, "/dz"}, 64'(divByZero), 64'(exp_dz));
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operandA  = '0;
        operandB  = '0;
        writeHi   = 1'b0;
        writeLo   = 1'b0;
        writeData = '0;
        tick;
        tick;
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/dz", 64'(divByZero), 64'd0);
        chk("reset/hi", 64'(hi), 64'd0);
        chk("reset/lo", 64'(lo), 64'd0);
        reset = 1'b0;
        tick;

        // Operations chain back to back: each start lands in the previous done cycle.
        run_op("multu_12x6", OP_MULTU, 32'd12, 32'd6, 32'd0, 32'd72, 34, 1'b0, 0);
        run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0, 0);
        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34, 1'b0, 2);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0, 0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 1'b0, 0);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 2, 1'b1, 0);
        run_op("divu_after0", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0, 0);
        run_op("mult_busy_ign", OP_MULT, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 34, 1'b0, 1);

        tick;
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("idle_hold_lo", 64'(lo), 64'hFFFF_FFEC);

        // Abort a DIV partway through with an asynchronous reset.
        op       = OP_DIV;
        operandA = 32'd1000;
        operandB = 32'd3;
        start    = 1'b1;
        tick;
        start = 1'b0;
        repeat (14) tick;
        chk("middiv/busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("middiv/busy", 64'(busy), 64'd0);
        chk("middiv/done", 64'(done), 64'd0);
        chk("middiv/hi", 64'(hi), 64'd0);
        chk("middiv/lo", 64'(lo), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick;
        writeHi   = 1'b1;
        writeData = 32'h0000_00AB;
        tick;
        writeHi = 1'b0;
        chk("mthi/hi", 64'(hi), 64'h0000_00AB);
        chk("mthi/lo", 64'(lo), 64'd0);
        chk("mthi/done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
